hnf_txreq_link: RTL

HNF_TXREQ_LINK -- requirements
Module: hnf_txreq_link

---
 rtl/hnf_txreq_link.sv | 111 +++++++++++
 1 files changed

// File: rtl/hnf_txreq_link.sv
// hnf_txreq_link: CHI TX REQ link layer with L-credit accounting, skid FIFO and link FSM.
// Optional feature: define HNF_TXREQ_PEND_EN for an exact registered TXREQFLITPEND.
// Flit layout used here: Opcode in bits [6:0], TxnID in bits [18:7], rest opaque.
// The output flit is a pure function of flops (FIFO head, state, credit count), so
// TXREQFLITV in the next cycle is known from next-state values and PEND can be exact.
module hnf_txreq_link #(
    parameter int BUF_DEPTH = 2,
    parameter int MAX_CRD   = 15,
    parameter int FLIT_W    = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              link_en,
    input  logic [FLIT_W-1:0] txreq_in,
    input  logic              txreq_in_valid,
    output logic              txreq_in_ready,
    output logic [FLIT_W-1:0] TXREQFLIT,
    output logic              TXREQFLITV,
    output logic              TXREQFLITPEND,
    input  logic              TXREQLCRDV,
    output logic              TXLINKACTIVEREQ,
    input  logic              TXLINKACTIVEACK,
    output logic [3:0]        crd_cnt,
    output logic [1:0]        link_state,
    output logic              crd_overflow
);
    typedef enum logic [1:0] {STOP = 2'd0, ACTIVATE = 2'd1, RUN = 2'd2, DEACTIVATE = 2'd3} state_t;
    localparam int AW = $clog2(BUF_DEPTH);

    state_t            state_q, state_d;
    logic [AW:0]       wr_q, wr_d, rd_q, rd_d;
    logic [FLIT_W-1:0] mem_q [BUF_DEPTH];
    logic [FLIT_W-1:0] mem_d [BUF_DEPTH];
    logic [3:0]        crd_q, crd_d;
    logic              ovf_q, ovf_d;
    logic              empty, full, push, pop, grant, saturate;

    assign empty           = wr_q == rd_q;
    assign full            = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign txreq_in_ready  = state_q == RUN && link_en && !full;
    assign push            = txreq_in_valid && txreq_in_ready;
    assign TXREQFLITV      = crd_q != 4'd0 && ((state_q == RUN && !empty) || state_q == DEACTIVATE);
    assign pop             = TXREQFLITV && state_q == RUN;
    assign TXREQFLIT       = pop ? mem_q[rd_q[AW-1:0]] : '0;
    assign grant           = TXREQLCRDV && state_q != STOP;
    assign saturate        = grant && !TXREQFLITV && crd_q == 4'(MAX_CRD);
    assign TXLINKACTIVEREQ = state_q == ACTIVATE || state_q == RUN;
    assign crd_cnt         = crd_q;
    assign link_state      = state_q;
    assign crd_overflow    = ovf_q;

    // Link FSM next state; leave DEACTIVATE only once no credit is held or arriving.
    always_comb begin
        state_d = state_q;
        case (state_q)
            STOP:       state_d = link_en ? ACTIVATE : STOP;
            ACTIVATE:   state_d = TXLINKACTIVEACK ? RUN : ACTIVATE;
            RUN:        state_d = (!link_en && empty) ? DEACTIVATE : RUN;
            DEACTIVATE: state_d = (!TXLINKACTIVEACK && crd_q == 4'd0 && !grant) ? STOP : DEACTIVATE;
            default:    state_d = STOP;
        endcase
    end

    // FIFO write/pointer update and credit bookkeeping.
    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_q[AW-1:0]] = txreq_in;
        wr_d  = wr_q + (AW+1)'(push);
        rd_d  = rd_q + (AW+1)'(pop);
        crd_d = saturate ? crd_q : crd_q + 4'(grant) - 4'(TXREQFLITV);
        ovf_d = ovf_q || saturate;
    end

    // Control state with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= STOP;
            wr_q    <= '0;
            rd_q    <= '0;
            crd_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            crd_q   <= crd_d;
            ovf_q   <= ovf_d;
        end
    end

    // FIFO storage needs no reset; the pointers define validity.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

`ifdef HNF_TXREQ_PEND_EN
    logic pend_q, pend_d;
    assign TXREQFLITPEND = pend_q;
    // Predict next-cycle TXREQFLITV from next-state values.
    always_comb begin
        pend_d = crd_d != 4'd0 && ((state_d == RUN && wr_d != rd_d) || state_d == DEACTIVATE);
    end
    // Registered pending indication.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) pend_q <= 1'b0;
        else        pend_q <= pend_d;
    end
`else
    assign TXREQFLITPEND = reset;
`endif
endmodule
